conv_interleave_commutator: RTL and testbench
=============================================

Name: conv_interleave_commutator

Overview:
Input/output commutator for the byte-wide convolutional interleaver. Distributes a packetised byte stream cyclically across BRANCHES delay lines; the branch delay lines are the registered shift chains (multiples of 17 stages) built from register_8bit. It aligns branch 0 to the packet sync byte, drives the per-branch write strobes and shared write data, and re-multiplexes the branch outputs into one interleaved output stream. Branch 0 has zero delay and is bypassed internally.

Parameters:
BRANCHES, 12, number of interleaver branches (commutator positions)
DATA_W, 8, byte width
PKT_LEN, 204, bytes per packet; must be an integer multiple of BRANCHES
MISS_MAX, 3, consecutive missing sync flags before lock is dropped

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  input byte qualifier
in_data  input  DATA_W  input byte
in_sync  input  1  high with the first byte of a packet (the 0x47 sync byte)
br_we  output  BRANCHES  one-hot write strobe to branch delay lines; bit 0 is never set
br_data  output  DATA_W  shared write data to the branch delay lines
br_rd_data  input  BRANCHES*DATA_W  concatenated branch outputs; slice k = bits [k*DATA_W +: DATA_W]; slice 0 is ignored
out_valid  output  1  interleaved byte qualifier
out_data  output  DATA_W  interleaved output byte
out_sync  output  1  high with the output byte taken from branch 0 at packet byte 0
locked  output  1  high in LOCK state

Behaviour:
- Reset (reset=0, asynchronous): state=HUNT; branch index sel=0; byte count bcnt=0; miss count=0; all outputs 0 (br_we=0, br_data=0, out_valid=0, out_data=0, out_sync=0, locked=0).
- Internal counters: sel 0..BRANCHES-1, bcnt 0..PKT_LEN-1, miss count 0..MISS_MAX. All advance only on cycles with in_valid=1.
- HUNT: no writes, out_valid=0. A cycle with in_valid=1 and in_sync=1 is accepted as packet byte 0 and is processed the same cycle as a LOCK byte with sel=0 and bcnt=0. The next state is LOCK, sel=1, bcnt=1, and miss count is cleared.
- LOCK, per valid byte:
  - br_we is registered, with bit sel=1 for one cycle when sel!=0.
  - br_data<=in_data.
  - out_data<=in_data if sel==0, otherwise slice sel of br_rd_data, sampled in the same cycle.
  - out_valid<=1.
  - out_sync<=(bcnt==0).
  - sel wraps from BRANCHES-1 to 0; bcnt wraps from PKT_LEN-1 to 0.
- LOCK with in_valid=0: br_we=0, out_valid=0, out_sync=0. Counters hold. out_data and br_data hold their last value.
- Latency: one clock from an in_valid byte to its out_valid/out_data and br_we/br_data.
- Sync checking in LOCK:
  - At bcnt==0, in_sync=1 clears the miss count.
  - At bcnt==0, in_sync=0 increments the miss count. The byte is still processed as packet byte 0, and out_sync is still asserted from the count.
  - When the miss count reaches MISS_MAX, the state returns to HUNT after that byte: sel=0, bcnt=0, locked=0.
  - in_sync=1 at bcnt!=0 is ignored (0x47 may occur in payload). It does not realign.
- locked is registered and reflects the state. It rises the cycle after the accepted sync byte and falls the cycle after the MISS_MAX-th miss.
- Back-pressure: none. Branch delay lines advance on every clk, so the input must be continuous within a packet for a correct interleave. Gaps are handled as above without corruption of the counters.
- Reset mid-packet forces HUNT immediately. Branch contents are not cleared by this block.

Test Plan:
- Reset then idle: reset=0 for 3 cycles, release with in_valid=0 -> all outputs 0, locked=0 for 10 cycles.
- Acquire: bytes 0x00,0x01 without sync, then 0x47 with in_sync=1, then continuous 0x01..0xCB -> no br_we before the sync byte; locked=1 the cycle after 0x47; out_data=0x47 with out_sync=1 one cycle after it; br_we sequence 0x002,0x004,…,0x800,0x000(bypass),0x002.
- Branch mux: tie slice k of br_rd_data to 0x10+k; in lock, drive bytes with sel=5 and sel=11 -> out_data=0x15 and 0x1B one cycle later; sel=0 byte 0xAA -> out_data=0xAA.
- Gaps: in lock, deassert in_valid for 4 cycles at bcnt=50 -> out_valid=0 and br_we=0 during the gap; the resumed byte uses sel=50 mod 12=2 and bcnt=50.
- Lock loss: 3 consecutive packets with in_sync=0 at bcnt=0 -> locked stays 1 through the first two misses and falls the cycle after the third packet-start byte. An in_sync=1 at bcnt=100 in between causes no realignment.
- Reset mid-operation: assert reset at bcnt=120 -> outputs 0 asynchronously; after release, HUNT until the next in_sync=1.

Source files
------------

// File: rtl/conv_interleave_commutator.sv
// Purpose : input/output commutator of the byte-wide convolutional interleaver. It aligns
//           branch 0 to the packet sync byte, strobes one branch delay line per byte and
//           re-multiplexes the branch outputs into the interleaved stream.
// Latency : 1 clk from an accepted in_valid byte to br_we/br_data and out_valid/out_data.
// Backpr. : none. Gaps in in_valid freeze the counters; the branch delay lines keep shifting.
// Ports   : clk, reset (async, active-low)
//           in_valid/in_data/in_sync   - packetised byte stream; in_sync marks the 0x47 byte
//           br_we/br_data              - one-hot branch write strobe and shared write data
//           br_rd_data                 - concatenated branch outputs, slice k = branch k
//           out_valid/out_data/out_sync - interleaved stream; out_sync marks branch 0, byte 0
//           locked                     - high while the commutator is aligned to sync
module conv_interleave_commutator #(
  parameter int BRANCHES = 12,
  parameter int DATA_W   = 8,
  parameter int PKT_LEN  = 204,
  parameter int MISS_MAX = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         in_sync,
  output logic [BRANCHES-1:0]          br_we,
  output logic [DATA_W-1:0]            br_data,
  input  logic [BRANCHES*DATA_W-1:0]   br_rd_data,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_data,
  output logic                         out_sync,
  output logic                         locked
);

  localparam int SEL_W  = (BRANCHES > 1) ? $clog2(BRANCHES) : 1;
  localparam int BC_W   = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam int MISS_W = $clog2(MISS_MAX + 1);

  localparam logic [SEL_W-1:0]    SEL_LAST  = SEL_W'(BRANCHES - 1);
  localparam logic [BC_W-1:0]     BCNT_LAST = BC_W'(PKT_LEN - 1);
  localparam logic [MISS_W-1:0]   MISS_LIM  = MISS_W'(MISS_MAX);
  localparam logic [BRANCHES-1:0] WE_ONE    = {{(BRANCHES-1){1'b0}}, 1'b1};

  typedef enum logic {ST_HUNT = 1'b0, ST_LOCK = 1'b1} state_t;

  state_t              r_state;
  logic [SEL_W-1:0]    r_sel;
  logic [BC_W-1:0]     r_bcnt;
  logic [MISS_W-1:0]   r_miss;
  logic [BRANCHES-1:0] r_br_we;
  logic [DATA_W-1:0]   r_br_data;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_sync;

  logic                w_take;
  logic [SEL_W-1:0]    w_sel;
  logic [BC_W-1:0]     w_bcnt;
  logic [SEL_W-1:0]    w_sel_nxt;
  logic [BC_W-1:0]     w_bcnt_nxt;
  logic [MISS_W-1:0]   w_miss_inc;
  logic [MISS_W-1:0]   w_miss_nxt;
  logic                w_drop;
  logic [DATA_W-1:0]   w_rd_byte;

  // A byte is processed in LOCK, or in HUNT when it carries the sync flag. The sync byte
  // seen in HUNT is handled as packet byte 0 on branch 0 in that same cycle.
  assign w_take = in_valid && ((r_state == ST_LOCK) || in_sync);
  assign w_sel  = (r_state == ST_LOCK) ? r_sel  : '0;
  assign w_bcnt = (r_state == ST_LOCK) ? r_bcnt : '0;

  assign w_sel_nxt  = (w_sel  == SEL_LAST)  ? '0 : w_sel  + SEL_W'(1);
  assign w_bcnt_nxt = (w_bcnt == BCNT_LAST) ? '0 : w_bcnt + BC_W'(1);

  // Sync flag is only judged at packet byte 0; a 0x47 inside the payload is ignored.
  assign w_miss_inc = r_miss + MISS_W'(1);
  always_comb begin
    w_miss_nxt = r_miss;
    if (w_bcnt == '0) begin
      w_miss_nxt = in_sync ? '0 : w_miss_inc;
    end
  end
  assign w_drop = (r_state == ST_LOCK) && (w_bcnt == '0) && !in_sync && (w_miss_inc == MISS_LIM);

  // Branch output mux; slice 0 is overridden by the bypass below.
  always_comb begin
    w_rd_byte = '0;
    for (int k = 0; k < BRANCHES; k++) begin
      if (w_sel == SEL_W'(k)) begin
        w_rd_byte = br_rd_data[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_HUNT;
      r_sel       <= '0;
      r_bcnt      <= '0;
      r_miss      <= '0;
      r_br_we     <= '0;
      r_br_data   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sync  <= 1'b0;
    end else begin
      r_br_we     <= '0;
      r_out_valid <= 1'b0;
      r_out_sync  <= 1'b0;
      if (w_take) begin
        // Branch 0 has zero delay: no strobe, input byte goes straight to the output.
        r_br_we     <= (w_sel == '0) ? '0 : (WE_ONE << w_sel);
        r_br_data   <= in_data;
        r_out_data  <= (w_sel == '0) ? in_data : w_rd_byte;
        r_out_valid <= 1'b1;
        r_out_sync  <= (w_bcnt == '0);
        if (w_drop) begin
          r_state <= ST_HUNT;
          r_sel   <= '0;
          r_bcnt  <= '0;
          r_miss  <= '0;
        end else begin
          r_state <= ST_LOCK;
          r_sel   <= w_sel_nxt;
          r_bcnt  <= w_bcnt_nxt;
          r_miss  <= w_miss_nxt;
        end
      end
    end
  end

  assign br_we     = r_br_we;
  assign br_data   = r_br_data;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sync  = r_out_sync;
  assign locked    = (r_state == ST_LOCK);

endmodule

// File: tb/tb_conv_interleave_commutator.sv
// Purpose : directed bench for conv_interleave_commutator (12 branches, 204-byte packets).
// Latency : outputs are sampled 1 ns after the rising edge that registers each byte.
// Backpr. : none; stimulus is continuous apart from the deliberate gap scenario.
module tb_conv_interleave_commutator;

  localparam int BR = 12;
  localparam int DW = 8;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic [DW-1:0]     in_data;
  logic              in_sync;
  logic [BR-1:0]     br_we;
  logic [DW-1:0]     br_data;
  logic [BR*DW-1:0]  br_rd_data;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic              out_sync;
  logic              locked;

  int nvec = 0;
  int nerr = 0;

  // Packed observation: {out_valid, out_sync, locked, br_we, out_data, br_data}
  logic [30:0] got;
  logic [30:0] exp_v;

  conv_interleave_commutator #(
    .BRANCHES(BR), .DATA_W(DW), .PKT_LEN(204), .MISS_MAX(3)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_sync(in_sync),
    .br_we(br_we), .br_data(br_data), .br_rd_data(br_rd_data),
    .out_valid(out_valid), .out_data(out_data), .out_sync(out_sync),
    .locked(locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb got = {out_valid, out_sync, locked, br_we, out_data, br_data};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic s);
    in_valid = 1'b1;
    in_data  = d;
    in_sync  = s;
    step();
  endtask

  task automatic gap();
    in_valid = 1'b0;
    in_sync  = 1'b0;
    step();
  endtask

  // Sends filler byte p at packet position p (p >= 1, so never a sync position) while locked.
  task automatic run_bytes(input int from, input int to, input string name);
    logic [BR-1:0] we;
    logic [7:0]    od;
    int            sel;
    for (int p = from; p <= to; p++) begin
      send(8'(p), 1'b0);
      sel = p % BR;
      we  = (sel == 0) ? '0 : (12'h001 << sel);
      od  = (sel == 0) ? 8'(p) : 8'(16 + sel);
      exp_v = {1'b1, 1'b0, 1'b1, we, od, 8'(p)};
      nvec++;
      if (got !== exp_v) begin
        nerr++;
        $display("FAIL %s bcnt=%0d got=%h want=%h", name, p, got, exp_v);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; in_data = '0; in_sync = 1'b0;
    repeat (3) step();
    nvec++;
    if (got !== 31'h0) begin nerr++; $display("FAIL reset_hold got=%h want=0", got); end
    #4 reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      nvec++;
      if (got !== 31'h0) begin nerr++; $display("FAIL reset_idle cyc=%0d got=%h want=0", i, got); end
    end
  endtask

  task automatic test_acquire();
    send(8'h00, 1'b0);
    nvec++;
    if ({out_valid, br_we, locked} !== 14'h0) begin
      nerr++; $display("FAIL acq_nosync0 got=%h want=0", {out_valid, br_we, locked});
    end
    send(8'h01, 1'b0);
    nvec++;
    if ({out_valid, br_we, locked} !== 14'h0) begin
      nerr++; $display("FAIL acq_nosync1 got=%h want=0", {out_valid, br_we, locked});
    end
    send(8'h47, 1'b1);
    exp_v = {1'b1, 1'b1, 1'b1, 12'h000, 8'h47, 8'h47};
    nvec++;
    if (got !== exp_v) begin nerr++; $display("FAIL acq_sync got=%h want=%h", got, exp_v); end
    run_bytes(1, 203, "acq_stream");
  endtask

  task automatic test_branch_mux();
    send(8'hAA, 1'b1);
    exp_v = {1'b1, 1'b1, 1'b1, 12'h000, 8'hAA, 8'hAA};
    nvec++;
    if (got !== exp_v) begin nerr++; $display("FAIL mux_sel0_sync got=%h want=%h", got, exp_v); end
    run_bytes(1, 4, "mux_fill_a");
    send(8'h99, 1'b0);
    exp_v = {1'b1, 1'b0, 1'b1, 12'h020, 8'h15, 8'h99};
    nvec++;
    if (got !== exp_v) begin nerr++; $display("FAIL mux_sel5 got=%h want=%h", got, exp_v); end
    run_bytes(6, 10, "mux_fill_b");
    send(8'h77, 1'b0);
    exp_v = {1'b1, 1'b0, 1'b1, 12'h800, 8'h1B, 8'h77};
    nvec++;
    if (got !== exp_v) begin nerr++; $display("FAIL mux_sel11 got=%h want=%h", got, exp_v); end
    send(8'hAA, 1'b0);
    exp_v = {1'b1, 1'b0, 1'b1, 12'h000, 8'hAA, 8'hAA};
    nvec++;
    if (got !== exp_v) begin nerr++; $display("FAIL mux_sel0_bypass got=%h want=%h", got, exp_v); end
    run_bytes(13, 49, "mux_fill_c");
  endtask

  task automatic test_gaps();
    // Last byte before the gap was bcnt 49 (data 0x31, branch 1 -> 0x11); both data regs hold.
    for (int i = 0; i < 4; i++) begin
      gap();
      exp_v = {1'b0, 1'b0, 1'b1, 12'h000, 8'h11, 8'h31};
      nvec++;
      if (got !== exp_v) begin nerr++; $display("FAIL gap_cyc%0d got=%h want=%h", i, got, exp_v); end
    end
    send(8'h33, 1'b0);
    exp_v = {1'b1, 1'b0, 1'b1, 12'h004, 8'h12, 8'h33};
    nvec++;
    if (got !== exp_v) begin nerr++; $display("FAIL gap_resume got=%h want=%h", got, exp_v); end
    run_bytes(51, 203, "gap_tail");
  endtask

  task automatic test_lock_loss();
    send(8'h00, 1'b0);
    exp_v = {1'b1, 1'b1, 1'b1, 12'h000, 8'h00, 8'h00};
    nvec++;
    if (got !== exp_v) begin nerr++; $display("FAIL miss1 got=%h want=%h", got, exp_v); end
    run_bytes(1, 99, "miss1_body");
    send(8'h47, 1'b1);
    exp_v = {1'b1, 1'b0, 1'b1, 12'h010, 8'h14, 8'h47};
    nvec++;
    if (got !== exp_v) begin nerr++; $display("FAIL payload_sync got=%h want=%h", got, exp_v); end
    run_bytes(101, 203, "miss1_tail");
    send(8'h00, 1'b0);
    exp_v = {1'b1, 1'b1, 1'b1, 12'h000, 8'h00, 8'h00};
    nvec++;
    if (got !== exp_v) begin nerr++; $display("FAIL miss2 got=%h want=%h", got, exp_v); end
    run_bytes(1, 203, "miss2_body");
    send(8'h00, 1'b0);
    exp_v = {1'b1, 1'b1, 1'b0, 12'h000, 8'h00, 8'h00};
    nvec++;
    if (got !== exp_v) begin nerr++; $display("FAIL miss3_drop got=%h want=%h", got, exp_v); end
    send(8'h01, 1'b0);
    nvec++;
    if ({out_valid, br_we, locked} !== 14'h0) begin
      nerr++; $display("FAIL hunt_after_drop got=%h want=0", {out_valid, br_we, locked});
    end
  endtask

  task automatic test_reset_mid();
    send(8'h47, 1'b1);
    nvec++;
    if ({locked, out_sync} !== 2'b11) begin
      nerr++; $display("FAIL reacq got=%b want=11", {locked, out_sync});
    end
    run_bytes(1, 119, "reacq_body");
    in_valid = 1'b1; in_data = 8'd120; in_sync = 1'b0;
    #2 reset = 1'b0;
    #1;
    nvec++;
    if (got !== 31'h0) begin nerr++; $display("FAIL async_reset got=%h want=0", got); end
    step();
    #3 reset = 1'b1;
    send(8'h05, 1'b0);
    nvec++;
    if ({out_valid, br_we, locked} !== 14'h0) begin
      nerr++; $display("FAIL post_reset_hunt got=%h want=0", {out_valid, br_we, locked});
    end
    send(8'h47, 1'b1);
    exp_v = {1'b1, 1'b1, 1'b1, 12'h000, 8'h47, 8'h47};
    nvec++;
    if (got !== exp_v) begin nerr++; $display("FAIL post_reset_sync got=%h want=%h", got, exp_v); end
    send(8'h01, 1'b0);
    exp_v = {1'b1, 1'b0, 1'b1, 12'h002, 8'h11, 8'h01};
    nvec++;
    if (got !== exp_v) begin nerr++; $display("FAIL post_reset_byte1 got=%h want=%h", got, exp_v); end
  endtask

  initial begin
    for (int k = 0; k < BR; k++) br_rd_data[k*DW +: DW] = 8'(16 + k);
    test_reset();
    test_acquire();
    test_branch_mux();
    test_gaps();
    test_lock_loss();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
